// File: rtl/m_mem_ctrl_if.sv
// Memory bus bundle between the M-stage memory controller and the data memory.
// Latency: none (wires only).
// Backpressure: request held by the master until a one-cycle ack pulse from the slave.
//
// Signals:
//   bus_req    master->slave  request, held high until ack or timeout
//   bus_we     master->slave  1 = store, 0 = load
//   bus_addr   master->slave  word-aligned byte address
//   bus_byteen master->slave  active byte lanes
//   bus_wdata  master->slave  lane-replicated store data
//   bus_ack    slave->master  one-cycle completion pulse
//   bus_rdata  slave->master  read word, valid with bus_ack
interface m_mem_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/m_mem_ctrl.sv
// M-stage memory controller: turns lw/lh/lhu/lb/lbu/sw/sh/sb into bus transactions.
// Latency: min 2 stall cycles (IDLE + one REQ cycle), result valid in DONE.
// Backpressure: M_stall freezes the pipeline until ack or MAX_WAIT-cycle timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   M_instr/M_ALUout/M_RD2   instruction, effective address, store data from E/M
//   bus (master modport)     memory bus request/response
//   M_RDout                  extended load result (non-zero only in DONE)
//   bus_err                  one-cycle timeout pulse in DONE
//   M_stall                  pipeline freeze
//   M_adel/M_ades            misaligned load/store flags, present only when
//                            MISALIGN_CHK_EN is defined
module m_mem_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         M_instr,
   input  logic [31:0]         M_ALUout,
   input  logic [31:0]         M_RD2,
   m_mem_ctrl_if.master        bus,
   output logic [31:0]         M_RDout,
   output logic                bus_err,
   output logic                M_stall
`ifdef MISALIGN_CHK_EN
   ,
   output logic                M_adel,
   output logic                M_ades
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic        ld_uns_q;
   size_t       ld_sz_q;
   logic [1:0]  ld_lane_q;
   logic        st_q;
   logic [31:0] rd_q;
   logic        err_q;

   // ---------------- decode ----------------
   logic        is_mem, is_st, is_uns, mem_go;
   size_t       sz;
   logic [3:0]  be_c;
   logic [31:0] wd_c;
   logic        unused_instr;

   assign unused_instr = ^M_instr[25:0];

   always_comb begin
      is_mem = 1'b1;
      is_st  = 1'b0;
      is_uns = 1'b0;
      sz     = SZ_WORD;
      case (M_instr[31:26])
         6'h23: sz = SZ_WORD;
         6'h21: sz = SZ_HALF;
         6'h25: begin sz = SZ_HALF; is_uns = 1'b1; end
         6'h20: sz = SZ_BYTE;
         6'h24: begin sz = SZ_BYTE; is_uns = 1'b1; end
         6'h2b: begin sz = SZ_WORD; is_st = 1'b1; end
         6'h29: begin sz = SZ_HALF; is_st = 1'b1; end
         6'h28: begin sz = SZ_BYTE; is_st = 1'b1; end
         default: is_mem = 1'b0;
      endcase
   end

`ifdef MISALIGN_CHK_EN
   logic misal;
   assign misal  = is_mem && (((sz == SZ_WORD) && (M_ALUout[1:0] != 2'b00)) ||
                              ((sz == SZ_HALF) && M_ALUout[0]));
   assign mem_go = is_mem && !misal;
   // A misaligned op never leaves IDLE, so flag it only there.
   assign M_adel = (state == S_IDLE) && misal && !is_st;
   assign M_ades = (state == S_IDLE) && misal && is_st;
`else
   assign mem_go = is_mem;
`endif

   // Lane enables and replicated store data; low address bits beyond the
   // access size are don't-care.
   always_comb begin
      be_c = 4'b1111;
      wd_c = M_RD2;
      case (sz)
         SZ_HALF: begin
            be_c = M_ALUout[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{M_RD2[15:0]}};
         end
         SZ_BYTE: begin
            be_c = 4'b0001 << M_ALUout[1:0];
            wd_c = {4{M_RD2[7:0]}};
         end
         default: begin
            be_c = 4'b1111;
            wd_c = M_RD2;
         end
      endcase
   end

   // ---------------- load extraction ----------------
   logic [31:0] ld_ext;
   logic [31:0] rd_shift;
   logic [15:0] rd_half;

   assign rd_shift = bus.bus_rdata >> {ld_lane_q, 3'b000};
   assign rd_half  = ld_lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

   always_comb begin
      ld_ext = bus.bus_rdata;
      case (ld_sz_q)
         SZ_BYTE: ld_ext = ld_uns_q ? {24'h0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
         SZ_HALF: ld_ext = ld_uns_q ? {16'h0, rd_half}
                                    : {{16{rd_half[15]}}, rd_half};
         default: ld_ext = bus.bus_rdata;
      endcase
   end

   // ---------------- FSM ----------------
   logic ack_hit, tmo_hit;
   assign ack_hit = (state == S_REQ) && bus.bus_ack;
   // Ack on the final wait cycle wins over the timeout.
   assign tmo_hit = (state == S_REQ) && !bus.bus_ack && (wait_cnt == LAST_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      M_stall   = 1'b0;
      case (state)
         S_IDLE: begin
            M_stall = mem_go;
            if (mem_go) state_nxt = S_REQ;
         end
         S_REQ: begin
            M_stall = 1'b1;
            if (ack_hit || tmo_hit) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt       <= 8'h0;
         bus.bus_req    <= 1'b0;
         bus.bus_we     <= 1'b0;
         bus.bus_addr   <= 32'h0;
         bus.bus_byteen <= 4'h0;
         bus.bus_wdata  <= 32'h0;
         ld_uns_q       <= 1'b0;
         ld_sz_q        <= SZ_WORD;
         ld_lane_q      <= 2'b00;
         st_q           <= 1'b0;
         rd_q           <= 32'h0;
         err_q          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               err_q <= 1'b0;
               rd_q  <= 32'h0;
               if (mem_go) begin
                  wait_cnt       <= 8'h0;
                  bus.bus_req    <= 1'b1;
                  bus.bus_we     <= is_st;
                  bus.bus_addr   <= {M_ALUout[31:2], 2'b00};
                  bus.bus_byteen <= be_c;
                  bus.bus_wdata  <= wd_c;
                  ld_uns_q       <= is_uns;
                  ld_sz_q        <= sz;
                  ld_lane_q      <= M_ALUout[1:0];
                  st_q           <= is_st;
               end
            end
            S_REQ: begin
               if (ack_hit) begin
                  bus.bus_req <= 1'b0;
                  rd_q        <= st_q ? 32'h0 : ld_ext;
               end else if (tmo_hit) begin
                  bus.bus_req <= 1'b0;
                  err_q       <= 1'b1;
                  rd_q        <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 8'h1;
               end
            end
            default: begin
               err_q <= 1'b0;
               rd_q  <= 32'h0;
            end
         endcase
      end
   end

   assign M_RDout = (state == S_DONE) ? rd_q : 32'h0;
   assign bus_err = err_q;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: plays the memory side of the bus.
// Latency: checks the 2-cycle minimum stall and the MAX_WAIT timeout.
// Backpressure: ack is injected after a per-test number of REQ cycles.
module tb_m_mem_ctrl;
   localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LHU = 6'h25, OP_LB = 6'h20,
                          OP_LBU = 6'h24, OP_SW = 6'h2b, OP_SH = 6'h29, OP_SB = 6'h28;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] M_instr, M_ALUout, M_RD2, M_RDout;
   logic        bus_err, M_stall;
`ifdef MISALIGN_CHK_EN
   logic        M_adel, M_ades;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   m_mem_ctrl_if bus ();

   m_mem_ctrl #(.MAX_WAIT(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .M_instr  (M_instr),
      .M_ALUout (M_ALUout),
      .M_RD2    (M_RD2),
      .bus      (bus),
      .M_RDout  (M_RDout),
      .bus_err  (bus_err),
      .M_stall  (M_stall)
`ifdef MISALIGN_CHK_EN
      ,
      .M_adel   (M_adel),
      .M_ades   (M_ades)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one memory op and acts as memory; ack_delay = REQ-cycle index
   // carrying the ack (-1 = never). Ends one cycle after DONE, back in IDLE.
   task automatic do_access(input logic [5:0] op, input logic [31:0] addr, rd2, rdata,
                            input int ack_delay,
                            output logic [31:0] o_addr, o_wdata, o_rdout,
                            output logic [3:0] o_be, output logic o_we, o_err,
                            output logic o_stable, o_req_done, o_err_next,
                            output int stall_cyc, req_cyc);
      M_instr  = {op, 26'h0};
      M_ALUout = addr;
      M_RD2    = rd2;
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 32'h5A5A_5A5A;
      o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
      o_stable = 1'b1; stall_cyc = 0; req_cyc = 0;
      #1;
      for (int c = 0; c < 64; c++) begin
         if (M_stall !== 1'b1) break;
         stall_cyc++;
         if (bus.bus_req === 1'b1) begin
            if (req_cyc == 0) begin
               o_addr = bus.bus_addr; o_wdata = bus.bus_wdata;
               o_be = bus.bus_byteen; o_we = bus.bus_we;
            end else if (o_addr !== bus.bus_addr || o_wdata !== bus.bus_wdata ||
                         o_be !== bus.bus_byteen || o_we !== bus.bus_we) begin
               o_stable = 1'b0;
            end
            bus.bus_ack   = (req_cyc == ack_delay);
            bus.bus_rdata = bus.bus_ack ? rdata : 32'h5A5A_5A5A;
            req_cyc++;
         end
         tick();
         bus.bus_ack = 1'b0;
         #1;
      end
      o_rdout    = M_RDout;
      o_err      = bus_err;
      o_req_done = bus.bus_req;
      M_instr    = 32'h0;
      tick();
      o_err_next = bus_err;
   endtask

   task automatic test_reset();
      rst = 1'b0; M_instr = 32'h0; M_ALUout = 32'h0; M_RD2 = 32'h0;
      bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
      tick(); tick();
      chk_cnt++;
      if ({bus.bus_req, bus.bus_we, bus.bus_byteen} !== 6'h0 || bus.bus_addr !== 32'h0 ||
          bus.bus_wdata !== 32'h0)
         $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
                  bus.bus_req, bus.bus_we, bus.bus_byteen, bus.bus_addr, bus.bus_wdata);
      else pass_cnt++;
      chk_cnt++;
      if ({bus_err, M_stall} !== 2'b00 || M_RDout !== 32'h0)
         $display("FAIL reset_out: err=%b stall=%b rdout=%h, required 0", bus_err, M_stall, M_RDout);
      else pass_cnt++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_nonmem();
      M_instr = {6'h00, 26'h3FF_FFFF};
      bus.bus_ack = 1'b1;
      #1;
      chk_cnt++;
      if (M_stall !== 1'b0) $display("FAIL nonmem_stall: got %b required 0", M_stall);
      else pass_cnt++;
      tick(); tick();
      chk_cnt++;
      if (bus.bus_req !== 1'b0 || M_RDout !== 32'h0)
         $display("FAIL nonmem_idle: req=%b rdout=%h, required 0/0", bus.bus_req, M_RDout);
      else pass_cnt++;
      bus.bus_ack = 1'b0; M_instr = 32'h0;
   endtask

   task automatic test_lw();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (a !== 32'h0000_1004 || be !== 4'b1111 || we !== 1'b0)
         $display("FAIL lw_req: addr=%h be=%b we=%b, required 00001004/1111/0", a, be, we);
      else pass_cnt++;
      chk_cnt++;
      if (sc != 2 || rc != 1) $display("FAIL lw_latency: stall=%0d req=%0d, required 2/1", sc, rc);
      else pass_cnt++;
      chk_cnt++;
      if (r !== 32'hDEAD_BEEF || e !== 1'b0 || rq !== 1'b0)
         $display("FAIL lw_done: rdout=%h err=%b req=%b, required deadbeef/0/0", r, e, rq);
      else pass_cnt++;
      chk_cnt++;
      if (M_RDout !== 32'h0) $display("FAIL lw_rdout_idle: got %h required 0", M_RDout);
      else pass_cnt++;
   endtask

   task automatic test_byte_loads();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_LB, 32'h0000_0003, 32'h0, 32'h80FF_FFFF, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (be !== 4'b1000 || a !== 32'h0 || r !== 32'hFFFF_FF80)
         $display("FAIL lb: be=%b addr=%h rdout=%h, required 1000/0/ffffff80", be, a, r);
      else pass_cnt++;
      do_access(OP_LBU, 32'h0000_0003, 32'h0, 32'h80FF_FFFF, 2, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (r !== 32'h0000_0080 || rc != 3 || st !== 1'b1)
         $display("FAIL lbu: rdout=%h req=%0d stable=%b, required 00000080/3/1", r, rc, st);
      else pass_cnt++;
      do_access(OP_LB, 32'h0000_0001, 32'h0, 32'h1122_7F44, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (be !== 4'b0010 || r !== 32'h0000_007F)
         $display("FAIL lb_lane1: be=%b rdout=%h, required 0010/0000007f", be, r);
      else pass_cnt++;
   endtask

   task automatic test_half_loads();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_LH, 32'h0000_0002, 32'h0, 32'h8001_1234, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (be !== 4'b1100 || r !== 32'hFFFF_8001)
         $display("FAIL lh_hi: be=%b rdout=%h, required 1100/ffff8001", be, r);
      else pass_cnt++;
      // addr[0] is ignored without the misalignment checker
      do_access(OP_LHU, 32'h0000_0001, 32'h0, 32'h8001_F234, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (be !== 4'b0011 || r !== 32'h0000_F234)
         $display("FAIL lhu_lo: be=%b rdout=%h, required 0011/0000f234", be, r);
      else pass_cnt++;
   endtask

   task automatic test_stores();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_SH, 32'h0000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (we !== 1'b1 || be !== 4'b1100 || w !== 32'hABCD_ABCD || r !== 32'h0)
         $display("FAIL sh: we=%b be=%b wdata=%h rdout=%h, required 1/1100/abcdabcd/0", we, be, w, r);
      else pass_cnt++;
      do_access(OP_SB, 32'h0000_0001, 32'h0000_00A5, 32'h0, 1, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (we !== 1'b1 || be !== 4'b0010 || w !== 32'hA5A5_A5A5 || st !== 1'b1)
         $display("FAIL sb: we=%b be=%b wdata=%h stable=%b, required 1/0010/a5a5a5a5/1", we, be, w, st);
      else pass_cnt++;
      do_access(OP_SW, 32'h0000_2003, 32'hCAFE_F00D, 32'h0, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (a !== 32'h0000_2000 || be !== 4'b1111 || w !== 32'hCAFE_F00D)
         $display("FAIL sw: addr=%h be=%b wdata=%h, required 00002000/1111/cafef00d", a, be, w);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_LW, 32'h0000_0100, 32'h0, 32'h1111_1111, -1, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (rc != 15 || sc != 16 || st !== 1'b1)
         $display("FAIL timeout_len: req=%0d stall=%0d stable=%b, required 15/16/1", rc, sc, st);
      else pass_cnt++;
      chk_cnt++;
      if (e !== 1'b1 || en !== 1'b0 || r !== 32'h0)
         $display("FAIL timeout_err: err=%b err_next=%b rdout=%h, required 1/0/0", e, en, r);
      else pass_cnt++;
      // ack on the last permitted cycle counts as a normal completion
      do_access(OP_LW, 32'h0000_0100, 32'h0, 32'h7777_0001, 14, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (rc != 15 || e !== 1'b0 || r !== 32'h7777_0001)
         $display("FAIL ack_at_timeout: req=%0d err=%b rdout=%h, required 15/0/77770001", rc, e, r);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_req();
      M_instr = {OP_LW, 26'h0}; M_ALUout = 32'h0000_0040; bus.bus_ack = 1'b0;
      tick(); tick(); tick();
      chk_cnt++;
      if (bus.bus_req !== 1'b1) $display("FAIL rst_mid_pre: req=%b required 1", bus.bus_req);
      else pass_cnt++;
      rst = 1'b0;
      tick();
      chk_cnt++;
      if (bus.bus_req !== 1'b0 || bus.bus_addr !== 32'h0 || bus.bus_byteen !== 4'h0)
         $display("FAIL rst_mid: req=%b addr=%h be=%b, required 0/0/0",
                  bus.bus_req, bus.bus_addr, bus.bus_byteen);
      else pass_cnt++;
      rst = 1'b1; M_instr = 32'h0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hBAD0_BAD0;
      tick();
      bus.bus_ack = 1'b0;
      chk_cnt++;
      if (bus.bus_req !== 1'b0 || M_RDout !== 32'h0 || bus_err !== 1'b0 || M_stall !== 1'b0)
         $display("FAIL late_ack: req=%b rdout=%h err=%b stall=%b, required all 0",
                  bus.bus_req, M_RDout, bus_err, M_stall);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, w, r; logic [3:0] be; logic we, e, st, rq, en; int sc, rc;
      do_access(OP_SW, 32'h0000_0010, 32'h0102_0304, 32'h0, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      do_access(OP_LBU, 32'h0000_0012, 32'h0, 32'h00AB_0000, 0, a, w, r, be, we, e, st, rq, en, sc, rc);
      chk_cnt++;
      if (we !== 1'b0 || be !== 4'b0100 || a !== 32'h0000_0010 || r !== 32'h0000_00AB || sc != 2)
         $display("FAIL back_to_back: we=%b be=%b addr=%h rdout=%h stall=%0d, required 0/0100/10/ab/2",
                  we, be, a, r, sc);
      else pass_cnt++;
   endtask

`ifdef MISALIGN_CHK_EN
   task automatic test_misalign();
      M_instr = {OP_LW, 26'h0}; M_ALUout = 32'h0000_1002;
      #1;
      chk_cnt++;
      if (M_adel !== 1'b1 || M_ades !== 1'b0 || M_stall !== 1'b0)
         $display("FAIL misalign_flags: adel=%b ades=%b stall=%b, required 1/0/0", M_adel, M_ades, M_stall);
      else pass_cnt++;
      tick(); tick();
      chk_cnt++;
      if (bus.bus_req !== 1'b0) $display("FAIL misalign_req: req=%b required 0", bus.bus_req);
      else pass_cnt++;
      M_instr = 32'h0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_nonmem();
      test_lw();
      test_byte_loads();
      test_half_loads();
      test_stores();
      test_timeout();
      test_reset_mid_req();
      test_back_to_back();
`ifdef MISALIGN_CHK_EN
      test_misalign();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
